mult_rr_scheduler: RTL and testbench

//  Shares one sequential signed multiplier among NREQ requesters. Arbitrates

---
 rtl/mult_rr_scheduler.sv | 176 +++++++++++++++++
 tb/tb_mult_rr_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler
//   Shares one sequential signed multiplier among NREQ requesters. A
//   round-robin arbiter picks one pending request while idle. The scheduler
//   latches that requester's operands, pulses the multiplier start, and waits
//   for the multiplier's ready. It then holds the 2*NB-bit product, tagged
//   with the requester index, until the consumer takes it.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   req_valid [NREQ]         per-requester request
//   req_a/req_b [NREQ*NB]    operands, requester i at [i*NB +: NB]
//   req_ready [NREQ]         one-hot acceptance pulse (valid in the IDLE cycle)
//   res_valid/res_ready      result handshake
//   res_product [2*NB]       signed product
//   res_id [IDW]             index of the requester owning the result
//   busy                     high whenever the scheduler is not idle
//   err_timeout              sticky multiplier-timeout flag, cleared by rst
//   mul_start/mul_a/mul_b    to the multiplier
//   mul_product/mul_ready    from the multiplier
// -----------------------------------------------------------------------------
module mult_rr_scheduler #(
    parameter int NB   = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int TMO  = NB + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*NB-1:0]   req_a,
    input  logic [NREQ*NB-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*NB-1:0]      res_product,
    output logic [IDW-1:0]       res_id,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 mul_start,
    output logic [NB-1:0]        mul_a,
    output logic [NB-1:0]        mul_b,
    input  logic [2*NB-1:0]      mul_product,
    input  logic                 mul_ready
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t              state_reg;
    logic [PW-1:0]       rr_ptr_reg;
    logic [TW-1:0]       tmo_cnt_reg;
    logic                res_valid_reg;
    logic [2*NB-1:0]     res_product_reg;
    logic [IDW-1:0]      res_id_reg;
    logic                busy_reg;
    logic                err_timeout_reg;
    logic                mul_start_reg;
    logic [NB-1:0]       mul_a_reg;
    logic [NB-1:0]       mul_b_reg;

    // Per-requester operand views.
    logic [NB-1:0] a_slice [NREQ];
    logic [NB-1:0] b_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi] = req_a[gi*NB +: NB];
            assign b_slice[gi] = req_b[gi*NB +: NB];
        end
    endgenerate

    // Round-robin search starting at rr_ptr. Scanning from the farthest
    // offset down lets the closest valid requester overwrite the result.
    logic          grant_any;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] next_ptr;

    always_comb begin
        int sum;
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = int'(rr_ptr_reg) + k;
            if (sum >= NREQ)
                sum = sum - NREQ;
            if (req_valid[sum]) begin
                grant_any = 1'b1;
                grant_idx = PW'(sum);
            end
        end
        next_ptr = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // The acceptance pulse must appear in the same cycle the operands are
    // sampled, so it is decoded from the idle state rather than registered.
    // It is forced low while rst is asserted so every output reads zero in reset.
    logic [NREQ-1:0] grant_onehot;
    assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
    assign req_ready    = (state_reg == IDLE && grant_any && !rst) ? grant_onehot : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            tmo_cnt_reg     <= '0;
            res_valid_reg   <= 1'b0;
            res_product_reg <= '0;
            res_id_reg      <= '0;
            busy_reg        <= 1'b0;
            err_timeout_reg <= 1'b0;
            mul_start_reg   <= 1'b0;
            mul_a_reg       <= '0;
            mul_b_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        mul_a_reg     <= a_slice[grant_idx];
                        mul_b_reg     <= b_slice[grant_idx];
                        res_id_reg    <= IDW'(grant_idx);
                        rr_ptr_reg    <= next_ptr;
                        mul_start_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= START;
                    end
                end
                START: begin
                    // mul_ready seen here still belongs to the previous
                    // operation, so it is not looked at.
                    mul_start_reg <= 1'b0;
                    tmo_cnt_reg   <= '0;
                    state_reg     <= WAIT;
                end
                WAIT: begin
                    if (mul_ready) begin
                        res_product_reg <= mul_product;
                        res_valid_reg   <= 1'b1;
                        state_reg       <= DONE;
                    end else if (tmo_cnt_reg == TW'(TMO - 1)) begin
                        // Give up: still return the tag so the owner is not stranded.
                        err_timeout_reg <= 1'b1;
                        res_product_reg <= '0;
                        res_valid_reg   <= 1'b1;
                        state_reg       <= DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign res_valid   = res_valid_reg;
    assign res_product = res_product_reg;
    assign res_id      = res_id_reg;
    assign busy        = busy_reg;
    assign err_timeout = err_timeout_reg;
    assign mul_start   = mul_start_reg;
    assign mul_a       = mul_a_reg;
    assign mul_b       = mul_b_reg;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mult_rr_scheduler
//   Drives directed requests into mult_rr_scheduler with a behavioural
//   sequential multiplier attached. A reference model holds a round-robin
//   pointer and a queue of outstanding results. One compare process checks
//   every cycle's outputs against it. Directed steps add literal expectations
//   for latency, products, tags, grant order, backpressure, reset and timeout.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_rr_scheduler;

    localparam int NB   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = NB + 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*NB-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid, res_ready;
    logic [2*NB-1:0]   res_product;
    logic [IDW-1:0]    res_id;
    logic              busy, err_timeout, mul_start;
    logic [NB-1:0]     mul_a, mul_b;
    logic [2*NB-1:0]   mul_product = 16'hDEAD;
    logic              mul_ready = 1'b1;   // multiplier powers up with junk

    mult_rr_scheduler #(.NB(NB), .NREQ(NREQ), .IDW(IDW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_product(res_product), .res_id(res_id),
        .busy(busy), .err_timeout(err_timeout),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_ready(mul_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural sequential multiplier ----------------
    // Ready rises NB edges after the edge that sees start. mul_hang
    // models a multiplier that never answers.
    bit               mul_hang = 1'b0;
    logic signed [NB-1:0] m_a, m_b;
    logic signed [2*NB-1:0] m_p;
    int               m_cnt = 0;
    bit               m_run = 1'b0;
    assign m_p = m_a * m_b;

    always @(posedge clk) begin
        if (mul_start) begin
            m_a       <= mul_a;
            m_b       <= mul_b;
            m_cnt     <= 0;
            mul_ready <= 1'b0;
            m_run     <= !mul_hang;
        end else if (m_run) begin
            if (m_cnt == NB - 1) begin
                mul_ready   <= 1'b1;
                mul_product <= m_p;
                m_run       <= 1'b0;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct { int id; logic [15:0] prod; } exp_t;
    exp_t        exp_q[$];
    int          model_ptr = 0;
    bit          acc_prev  = 1'b0;
    logic [7:0]  last_a, last_b;

    always @(negedge clk) begin
        int g;
        int p;
        bit idle_exp;
        logic [7:0] a8, b8;
        exp_t e;
        if (rst) begin
            model_ptr = 0;
            exp_q.delete();
            acc_prev = 1'b0;
        end else begin
            idle_exp = (exp_q.size() == 0);
            check("busy", busy, !idle_exp);
            check("mul_start", mul_start, acc_prev);
            if (mul_start) begin
                check("mul_a", mul_a, last_a);
                check("mul_b", mul_b, last_b);
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_valid_unexpected", res_valid, 0);
                end else begin
                    check("res_id", res_id, exp_q[0].id);
                    check("res_product", res_product, exp_q[0].prod);
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
            acc_prev = 1'b0;
            if (idle_exp && req_valid != 0) begin
                g = 0;
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (model_ptr + k) % NREQ;
                    if (req_valid[j]) begin
                        g = j;
                        break;
                    end
                end
                check("req_ready_grant", req_ready, 4'b0001 << g);
                a8 = req_a[g*NB +: NB];
                b8 = req_b[g*NB +: NB];
                p  = $signed(a8) * $signed(b8);
                e.id   = g;
                e.prod = mul_hang ? 16'h0000 : p[15:0];
                exp_q.push_back(e);
                last_a = a8;
                last_b = b8;
                model_ptr = (g + 1) % NREQ;
                acc_prev = 1'b1;
            end else begin
                check("req_ready_idle", req_ready, 0);
            end
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic wait_accept(input int i, output int c);
        c = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                c = cyc;
                return;
            end
        end
        check("accept_wait", 0, 1);
    endtask

    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, output int c);
        req_a[i*NB +: NB] = a;
        req_b[i*NB +: NB] = b;
        req_valid[i] = 1'b1;
        wait_accept(i, c);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_result(input int acc, output int lat);
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = cyc - acc;
                return;
            end
        end
        check("result_wait", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_product"}, res_product, 0);
        check({tag, "_res_id"}, res_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
    endtask

    task automatic single_op(input string tag, input int i, input logic [7:0] a,
                             input logic [7:0] b, input logic [15:0] prod, input int lat_exp);
        int acc, lat;
        issue(i, a, b, acc);
        wait_result(acc, lat);
        check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_id"}, res_id, i);
        check({tag, "_product"}, res_product, prod);
        $display("op %s: req%0d A=%02h B=%02h -> id=%0d product=%04h latency=%0d",
                 tag, i, a, b, res_id, res_product, lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int order_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        int acc, lat, idx, prev_acc;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b1;

        // Reset state, with requests pending to show nothing is accepted.
        repeat (2) @(posedge clk);
        #1 req_valid = 4'hF;
        #2 check_all_zero("reset");
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        $display("reset: outputs zero");

        // Single request and signed operands.
        single_op("single", 0, 8'h07, 8'h06, 16'h002A, NB + 3);
        single_op("neg_pos", 2, 8'hFD, 8'h05, 16'hFFF1, NB + 3);
        single_op("min_min", 1, 8'h80, 8'h80, 16'h4000, NB + 3);

        // All four requesting continuously: round-robin from a fresh pointer.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        req_a = {8'h80, 8'h7F, 8'hFE, 8'h03};
        req_b = {8'h7F, 8'h7F, 8'h07, 8'h04};
        req_valid = 4'hF;
        prev_acc = 0;
        for (int k = 0; k < 5; k++) begin
            idx = -1;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (req_ready != 0) break;
            end
            for (int j = 0; j < NREQ; j++)
                if (req_ready[j]) idx = j;
            check("rr_order", idx, order_exp[k]);
            if (k > 0) check("rr_throughput", cyc - prev_acc, NB + 4);
            $display("rr grant %0d: req%0d at cycle %0d", k, idx, cyc);
            prev_acc = cyc;
            @(posedge clk);
        end
        #1 req_valid = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        @(posedge clk);
        #1;

        // Backpressure in DONE with another request pending.
        res_ready = 1'b0;
        issue(1, 8'h11, 8'h03, acc);
        wait_result(acc, lat);
        @(posedge clk);
        #1 req_a[2*NB +: NB] = 8'h0A;
        req_b[2*NB +: NB] = 8'hF6;
        req_valid[2] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("bp_res_valid", res_valid, 1);
            check("bp_res_product", res_product, 16'h0033);
            check("bp_res_id", res_id, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_mul_start", mul_start, 0);
        end
        $display("backpressure: held id=%0d product=%04h for 20 cycles", res_id, res_product);
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_accept(2, acc);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        wait_result(acc, lat);
        check("bp_next_id", res_id, 2);
        check("bp_next_product", res_product, 16'hFF9C);
        $display("op after backpressure: id=%0d product=%04h", res_id, res_product);
        @(posedge clk);
        #1;

        // Reset in the middle of WAIT.
        issue(0, 8'h12, 8'h34, acc);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #2 check_all_zero("midrst");
        $display("reset mid-WAIT: outputs zero");
        @(posedge clk);
        #1 rst = 1'b0;
        single_op("after_rst", 3, 8'hFF, 8'hFF, 16'h0001, NB + 3);

        // Timeout with a silent multiplier.
        check("tmo_before", err_timeout, 0);
        mul_hang = 1'b1;
        issue(2, 8'h05, 8'h05, acc);
        wait_result(acc, lat);
        check("tmo_latency", lat, TMO + 2);
        check("tmo_err", err_timeout, 1);
        check("tmo_product", res_product, 0);
        check("tmo_id", res_id, 2);
        $display("timeout: id=%0d product=%04h err=%0d latency=%0d", res_id, res_product, err_timeout, lat);
        @(posedge clk);
        #1 mul_hang = 1'b0;
        single_op("post_tmo", 0, 8'h02, 8'h03, 16'h0006, NB + 3);
        repeat (3) @(posedge clk);
        #1 check("tmo_sticky", err_timeout, 1);
        rst = 1'b1;
        #2 check("tmo_cleared", err_timeout, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        $display("timeout flag cleared by reset");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
